pipemem_stage: RTL and testbench
================================

Name: pipemem_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register; consumes mwreg, mm2reg, mwmem, malu, mb, mrn.
- Runs the data-memory access over a request/acknowledge bus and stalls the upstream pipeline while memory is slow.
- Contains the MEM/WB pipeline register that feeds write-back.
- Includes a wait-state watchdog that aborts hung accesses.

Parameters:
- TIMEOUT, 15, maximum WAIT cycles before an access is aborted; 0 disables the watchdog. Range 0..255.

Ports:
- clock  in  1  pipeline clock, all flops on rising edge
- reset  in  1  asynchronous, active-high reset
- mwreg  in  1  register-write enable from EX/MEM
- mm2reg  in  1  load: write-back data comes from memory
- mwmem  in  1  store: write memory
- malu  in  32  ALU result, used as memory address
- mb  in  32  store data
- mrn  in  5  destination register number
- dreq  out  1  memory request (combinational)
- dwe  out  1  memory write enable, valid with dreq
- daddr  out  32  memory address, equals malu
- dwdata  out  32  memory write data, equals mb
- drdata  in  32  memory read data, valid with dack
- dack  in  1  memory acknowledge, access completes in the cycle it is high with dreq
- mstall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle
- wwreg  out  1  MEM/WB register-write enable
- wm2reg  out  1  MEM/WB select-memory-data
- wmo  out  32  MEM/WB loaded memory data
- walu  out  32  MEM/WB ALU result
- wrn  out  5  MEM/WB destination register
- derr  out  1  sticky: an access timed out

Behaviour:
- memop = mwmem | mm2reg. States: IDLE, WAIT. Reset state is IDLE.
- Reset (asynchronous, any time including mid-access):
  - state returns to IDLE.
  - wait counter, wwreg, wm2reg, wmo, walu, wrn and derr all go to 0.
  - dreq drops immediately.
- dreq = (IDLE & memop) | WAIT.
- dwe = mwmem & dreq. daddr = malu; dwdata = mb. Inputs stay stable while stalled because upstream is frozen.
- mstall = dreq & ~dack & ~abort.
  - abort = WAIT & (TIMEOUT != 0) & (count == TIMEOUT-1) & ~dack.
- IDLE, memop=0:
  - At the next edge MEM/WB loads wwreg<=mwreg, wm2reg<=mm2reg, walu<=malu, wrn<=mrn. wmo holds.
  - Latency is 1 cycle.
- IDLE, memop=1, dack=1 (zero-wait memory):
  - Completes in one cycle with no stall.
  - MEM/WB loads as for a non-memory op. wmo<=drdata if mm2reg, otherwise wmo holds.
- IDLE, memop=1, dack=0: go to WAIT, count<=0, mstall=1.
- WAIT, dack=1: complete as above and return to IDLE.
- WAIT, dack=0:
  - count increments.
  - On abort: return to IDLE, derr<=1, and load a bubble into MEM/WB (wwreg<=0, wm2reg<=0).
  - The aborted instruction is retired without write-back. On that abort cycle mstall=0, so the pipeline advances.
- Stalled cycles (mstall=1): MEM/WB loads a bubble: wwreg<=0, wm2reg<=0. walu, wrn and wmo hold. A stall therefore never causes a duplicate register write.
- dack while dreq=0 is ignored.
- mwmem=1 and mm2reg=1 together: one access with dwe=1. drdata is captured into wmo and wm2reg=1. The decoder never issues this combination, but the behaviour is defined.
- derr is cleared only by reset.
- Counter is 8 bits. It cannot wrap when TIMEOUT is 0 (saturates at 255).

Decomposition:
- Shared package pipe_pkg:
  - state encoding constants ST_IDLE=1'b0, ST_WAIT=1'b1.
  - widths: DATA_W=32, RN_W=5.
- One natural sub-module: pipemwreg, the MEM/WB register with load and bubble controls.
- FSM, watchdog and bus logic stay in pipemem_stage.

Test Plan:
- ALU op (mwreg=1, mm2reg=0, mwmem=0, malu=0x0000_1234, mrn=5), dack=0 -> dreq=0, mstall=0; next edge wwreg=1, walu=0x1234, wrn=5.
- Load malu=0x40, mm2reg=1, mwreg=1, dack tied 1, drdata=0xDEADBEEF -> no stall; next edge wmo=0xDEADBEEF, wm2reg=1, wwreg=1.
- Store malu=0x80, mb=0xA5A5_0001, dack high on 3rd request cycle:
  - dreq=1, dwe=1, daddr=0x80 and dwdata=0xA5A50001 held for 3 cycles.
  - mstall=1 for 2 cycles, and wwreg=0 during the stall.
- Load with dack never asserted, TIMEOUT=4:
  - mstall=1 for the IDLE request cycle plus 3 WAIT cycles, then 0 on the abort cycle.
  - derr=1 from the next edge and stays high; wwreg=0; state returns to IDLE.
- Assert reset while in WAIT -> dreq, mstall, wwreg and derr drop to 0 asynchronously. After release, a new ALU op passes in 1 cycle.
- dack pulse while dreq=0, then back-to-back loads each acked in the first cycle -> stray dack ignored; two consecutive MEM/WB loads with correct wmo values and no stall.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared widths and FSM encoding for the MEM stage and its MEM/WB register.
package pipe_pkg;
  localparam int DATA_W = 32;
  localparam int RN_W   = 5;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;
endpackage

// File: rtl/pipemwreg.sv
// MEM/WB pipeline register: loads when the pipeline advances, or takes a bubble
// (write controls cleared, data fields held) when stalled or aborted.
module pipemwreg
  import pipe_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_bubble,
  input  logic              i_load_mo,
  input  logic              i_wreg,
  input  logic              i_m2reg,
  input  logic [DATA_W-1:0] i_mo,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [RN_W-1:0]   i_rn,
  output logic              o_wreg,
  output logic              o_m2reg,
  output logic [DATA_W-1:0] o_mo,
  output logic [DATA_W-1:0] o_alu,
  output logic [RN_W-1:0]   o_rn
);
  logic              r_wreg;
  logic              r_m2reg;
  logic [DATA_W-1:0] r_mo;
  logic [DATA_W-1:0] r_alu;
  logic [RN_W-1:0]   r_rn;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_mo    <= '0;
      r_alu   <= '0;
      r_rn    <= '0;
    end else if (i_bubble) begin
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
    end else if (i_load) begin
      r_wreg  <= i_wreg;
      r_m2reg <= i_m2reg;
      r_alu   <= i_alu;
      r_rn    <= i_rn;
      if (i_load_mo) r_mo <= i_mo;
    end
  end

  assign o_wreg  = r_wreg;
  assign o_m2reg = r_m2reg;
  assign o_mo    = r_mo;
  assign o_alu   = r_alu;
  assign o_rn    = r_rn;
endmodule

// File: rtl/pipemem_stage.sv
// MEM stage: drives the data-memory request/ack bus, stalls upstream while the
// memory is slow, aborts hung accesses via a watchdog, and owns MEM/WB.
module pipemem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mwreg,
  input  logic              mm2reg,
  input  logic              mwmem,
  input  logic [DATA_W-1:0] malu,
  input  logic [DATA_W-1:0] mb,
  input  logic [RN_W-1:0]   mrn,
  output logic              dreq,
  output logic              dwe,
  output logic [DATA_W-1:0] daddr,
  output logic [DATA_W-1:0] dwdata,
  input  logic [DATA_W-1:0] drdata,
  input  logic              dack,
  output logic              mstall,
  output logic              wwreg,
  output logic              wm2reg,
  output logic [DATA_W-1:0] wmo,
  output logic [DATA_W-1:0] walu,
  output logic [RN_W-1:0]   wrn,
  output logic              derr
);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic             r_derr;

  logic w_memop;
  logic w_dreq;
  logic w_abort;
  logic w_complete;
  logic w_mstall;
  logic w_bubble;

  assign w_memop    = mwmem | mm2reg;
  // Gated by reset so the request drops the instant reset asserts, not at the next edge.
  assign w_dreq     = ~reset & (((r_state == ST_IDLE) & w_memop) | (r_state == ST_WAIT));
  assign w_abort    = (r_state == ST_WAIT) && (TIMEOUT != 0) && (r_count == TO_LAST) && !dack;
  assign w_complete = w_dreq & dack;
  assign w_mstall   = w_dreq & ~dack & ~w_abort;
  assign w_bubble   = w_mstall | w_abort;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_derr  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_memop && !dack) begin
            r_state <= ST_WAIT;
            r_count <= '0;
          end
        end
        ST_WAIT: begin
          if (dack) begin
            r_state <= ST_IDLE;
          end else if (w_abort) begin
            r_state <= ST_IDLE;
            r_derr  <= 1'b1;
          end else if (r_count != CNT_MAX) begin
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  pipemwreg u_mwreg (
    .clock     (clock),
    .reset     (reset),
    .i_load    (~w_bubble),
    .i_bubble  (w_bubble),
    .i_load_mo (w_complete & mm2reg),
    .i_wreg    (mwreg),
    .i_m2reg   (mm2reg),
    .i_mo      (drdata),
    .i_alu     (malu),
    .i_rn      (mrn),
    .o_wreg    (wwreg),
    .o_m2reg   (wm2reg),
    .o_mo      (wmo),
    .o_alu     (walu),
    .o_rn      (wrn)
  );

  assign dreq   = w_dreq;
  assign dwe    = mwmem & w_dreq;
  assign daddr  = malu;
  assign dwdata = mb;
  assign mstall = w_mstall;
  assign derr   = r_derr;
endmodule

// File: tb/tb_pipemem_stage.sv
// Scoreboard bench for pipemem_stage: the driver pushes per-instruction expectations,
// a monitor pops them when an instruction retires from MEM.
module tb_pipemem_stage;
  localparam int TB_TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mwreg = 1'b0, mm2reg = 1'b0, mwmem = 1'b0;
  logic [31:0] malu = '0, mb = '0, drdata = '0;
  logic [4:0]  mrn = '0;
  logic        dack = 1'b0;
  logic        dreq, dwe, mstall, wwreg, wm2reg, derr;
  logic [31:0] daddr, dwdata, wmo, walu;
  logic [4:0]  wrn;

  pipemem_stage #(.TIMEOUT(TB_TO)) dut (
    .clock(clock), .reset(reset), .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .malu(malu), .mb(mb), .mrn(mrn), .dreq(dreq), .dwe(dwe), .daddr(daddr),
    .dwdata(dwdata), .drdata(drdata), .dack(dack), .mstall(mstall), .wwreg(wwreg),
    .wm2reg(wm2reg), .wmo(wmo), .walu(walu), .wrn(wrn), .derr(derr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wreg;
    logic        m2reg;
    logic [31:0] mo;
    logic [31:0] alu;
    logic [4:0]  rn;
    logic        derr;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  bit cur_valid = 1'b0;

  // Architectural state of MEM/WB as the bench understands it.
  logic [31:0] m_alu = '0, m_mo = '0;
  logic [4:0]  m_rn = '0;
  logic        m_derr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // lat: request cycle on which dack rises (0 = never); for non-memory ops lat!=0 drives a stray dack.
  task automatic issue(input logic mw, input logic m2, input logic mm, input logic [31:0] alu,
                       input logic [31:0] b, input logic [4:0] rn, input int lat,
                       input logic [31:0] rd);
    exp_t e;
    int   stalls;
    bit   memop;
    bit   done;
    memop = m2 | mm;
    if (!memop) begin
      stalls = 0; done = 1'b1;
    end else if (lat >= 1 && lat <= TB_TO + 1) begin
      stalls = lat - 1; done = 1'b1;
    end else begin
      stalls = TB_TO; done = 1'b0;
    end
    if (done) begin
      m_alu = alu; m_rn = rn;
      if (memop && m2) m_mo = rd;
      e.wreg = mw; e.m2reg = m2;
    end else begin
      m_derr = 1'b1;
      e.wreg = 1'b0; e.m2reg = 1'b0;
    end
    e.mo = m_mo; e.alu = m_alu; e.rn = m_rn; e.derr = m_derr; e.stalls = stalls;
    sb_q.push_back(e);
    for (int k = 1; k <= stalls + 1; k++) begin
      @(negedge clock);
      cur_valid = 1'b1;
      mwreg = mw; mm2reg = m2; mwmem = mm; malu = alu; mb = b; mrn = rn;
      dack   = memop ? (k == lat) : (lat != 0);
      drdata = (k == lat) ? rd : $urandom;
    end
  endtask

  // Monitor: runs mid-cycle; checks the bus for the presented instruction and MEM/WB for the previous edge.
  initial begin
    bit   have_prev;
    bit   prev_stall;
    int   stall_cnt;
    exp_t e;
    have_prev = 0; prev_stall = 0; stall_cnt = 0;
    forever begin
      @(negedge clock);
      #2;
      if (!mon_en) begin
        have_prev = 0; prev_stall = 0; stall_cnt = 0;
      end else begin
        if (have_prev) begin
          if (prev_stall) begin
            chk("stall_bubble_wwreg", wwreg, 0);
            chk("stall_bubble_wm2reg", wm2reg, 0);
          end else if (sb_q.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("stall_cycles", stall_cnt, e.stalls);
            chk("wwreg", wwreg, e.wreg);
            chk("wm2reg", wm2reg, e.m2reg);
            chk("wmo", wmo, e.mo);
            chk("walu", walu, e.alu);
            chk("wrn", wrn, e.rn);
            chk("derr", derr, e.derr);
            stall_cnt = 0;
          end
        end
        if (cur_valid) begin
          chk("dreq", dreq, mwmem | mm2reg);
          chk("dwe", dwe, mwmem);
          if (mwmem | mm2reg) begin
            chk("daddr", daddr, malu);
            chk("dwdata", dwdata, mb);
          end
        end
        prev_stall = mstall;
        if (mstall) stall_cnt++;
        have_prev = cur_valid;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    #3;
    chk("rst_dreq", dreq, 0);
    chk("rst_mstall", mstall, 0);
    chk("rst_wwreg", wwreg, 0);
    chk("rst_wm2reg", wm2reg, 0);
    chk("rst_wmo", wmo, 0);
    chk("rst_walu", walu, 0);
    chk("rst_wrn", wrn, 0);
    chk("rst_derr", derr, 0);
    @(negedge clock);
    reset = 1'b0;
    mon_en = 1'b1;

    issue(1, 0, 0, 32'h0000_1234, 32'h0, 5'd5, 0, 32'h0);
    issue(1, 1, 0, 32'h0000_0040, 32'h0, 5'd6, 1, 32'hDEAD_BEEF);
    issue(0, 0, 1, 32'h0000_0080, 32'hA5A5_0001, 5'd0, 3, 32'h0);
    issue(1, 1, 0, 32'h0000_00C0, 32'h0, 5'd9, 0, 32'h1111_2222);
    issue(1, 0, 0, 32'h0000_0300, 32'h0, 5'd10, 1, 32'h0);
    issue(1, 1, 0, 32'h0000_0044, 32'h0, 5'd11, 1, 32'hCAFE_0001);
    issue(1, 1, 0, 32'h0000_0048, 32'h0, 5'd12, 1, 32'hCAFE_0002);
    issue(1, 1, 1, 32'h0000_0050, 32'h7777_0000, 5'd13, 2, 32'h1357_9BDF);
    issue(1, 1, 0, 32'h0000_0054, 32'h0, 5'd14, TB_TO + 1, 32'h2468_ACE0);
    issue(1, 1, 0, 32'h0000_0058, 32'h0, 5'd15, TB_TO + 2, 32'h0BAD_0BAD);

    for (int n = 0; n < 150; n++) begin
      int kind;
      kind = $urandom_range(0, 3);
      issue($urandom_range(0, 1), kind == 1 || kind == 3, kind == 2 || kind == 3,
            $urandom, $urandom, 5'($urandom), $urandom_range(0, TB_TO + 2), $urandom);
    end

    @(negedge clock);
    cur_valid = 1'b0;
    mwreg = 0; mm2reg = 0; mwmem = 0; dack = 0;
    repeat (2) @(negedge clock);
    chk("sb_drained", sb_q.size(), 0);

    mon_en = 1'b0;
    mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h100; mrn = 5'd3; dack = 0;
    @(negedge clock);
    @(negedge clock);
    #2;
    chk("pre_reset_dreq", dreq, 1);
    chk("pre_reset_derr", derr, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_dreq", dreq, 0);
    chk("async_rst_mstall", mstall, 0);
    chk("async_rst_wwreg", wwreg, 0);
    chk("async_rst_derr", derr, 0);
    @(negedge clock);
    reset = 1'b0;
    mwreg = 1; mm2reg = 0; mwmem = 0; malu = 32'h55; mrn = 5'd7; dack = 0;
    #2;
    chk("post_rst_mstall", mstall, 0);
    chk("post_rst_dreq", dreq, 0);
    @(negedge clock);
    mwreg = 0;
    #2;
    chk("post_rst_wwreg", wwreg, 1);
    chk("post_rst_walu", walu, 32'h55);
    chk("post_rst_wrn", wrn, 7);
    chk("post_rst_derr", derr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
